// File: rtl/sc_shiftsel_sequencer.sv
// sc_shiftsel_sequencer
// Upstream stage of the register shifter: holds a DATAWIDTH-bit pattern that
// can be loaded from switches, rotates it once per prescaled tick during a run,
// and presents it on the shifter's selection bus.
//
// Ports:
//   SC_RegSHIFTER_CLOCK_50      in   system clock (50 MHz)
//   SC_RegSHIFTER_RESET_InHigh  in   asynchronous active-high reset
//   seq_load_In                 in   capture seq_pattern_In (IDLE only)
//   seq_pattern_In              in   pattern to load
//   seq_start_In                in   start a run (IDLE only)
//   seq_stop_In                 in   abort a run (RUN only)
//   seq_dir_In                  in   0 = rotate left, 1 = rotate right
//   seq_steps_In                in   rotations per run, 0 = until stopped
//   seq_shiftselection_OutBUS   out  current pattern
//   seq_strobe_Out              out  one-cycle pulse after every bus update
//   seq_busy_Out                out  high while running
//   seq_done_Out                out  one-cycle pulse when a counted run ends
module sc_shiftsel_sequencer #(
    parameter int                   DATAWIDTH     = 8,
    parameter int                   TICK_DIV      = 50000000,
    parameter int                   STEPS_WIDTH   = 4,
    parameter logic [DATAWIDTH-1:0] RESET_PATTERN = 8'h0F
) (
    input  logic                   SC_RegSHIFTER_CLOCK_50,
    input  logic                   SC_RegSHIFTER_RESET_InHigh,
    input  logic                   seq_load_In,
    input  logic [DATAWIDTH-1:0]   seq_pattern_In,
    input  logic                   seq_start_In,
    input  logic                   seq_stop_In,
    input  logic                   seq_dir_In,
    input  logic [STEPS_WIDTH-1:0] seq_steps_In,
    output logic [DATAWIDTH-1:0]   seq_shiftselection_OutBUS,
    output logic                   seq_strobe_Out,
    output logic                   seq_busy_Out,
    output logic                   seq_done_Out
);

    localparam int              PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                 r_state,   w_state_next;
    logic [DATAWIDTH-1:0]   r_pattern, w_pattern_next;
    logic [PS_W-1:0]        r_presc,   w_presc_next;
    logic [STEPS_WIDTH-1:0] r_count,   w_count_next;
    logic [STEPS_WIDTH-1:0] r_steps,   w_steps_next;
    logic                   r_dir,     w_dir_next;
    logic                   r_strobe,  w_strobe_next;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_tick;
    logic [STEPS_WIDTH-1:0] w_count_inc;
    logic [DATAWIDTH-1:0]   w_rotated;

    always_comb begin
        w_tick      = (r_presc == PS_LAST);
        w_count_inc = r_count + 1'b1;
        w_rotated   = r_dir ? {r_pattern[0], r_pattern[DATAWIDTH-1:1]}
                            : {r_pattern[DATAWIDTH-2:0], r_pattern[DATAWIDTH-1]};

        w_state_next   = r_state;
        w_pattern_next = r_pattern;
        w_presc_next   = r_presc;
        w_count_next   = r_count;
        w_steps_next   = r_steps;
        w_dir_next     = r_dir;
        w_strobe_next  = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Load and start may coincide: the run then rotates the new pattern.
                if (seq_load_In) begin
                    w_pattern_next = seq_pattern_In;
                    w_strobe_next  = 1'b1;
                end
                if (seq_start_In) begin
                    w_dir_next   = seq_dir_In;
                    w_steps_next = seq_steps_In;
                    w_presc_next = '0;
                    w_count_next = '0;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                // Stop wins over a coincident tick: no rotation, no done.
                if (seq_stop_In) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_presc_next = w_tick ? '0 : r_presc + 1'b1;
                    if (w_tick) begin
                        w_pattern_next = w_rotated;
                        w_strobe_next  = 1'b1;
                        w_count_next   = w_count_inc;
                        if ((r_steps != '0) && (w_count_inc == r_steps))
                            w_state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge SC_RegSHIFTER_CLOCK_50 or posedge SC_RegSHIFTER_RESET_InHigh) begin
        if (SC_RegSHIFTER_RESET_InHigh) begin
            r_state   <= S_IDLE;
            r_pattern <= RESET_PATTERN;
            r_presc   <= '0;
            r_count   <= '0;
            r_steps   <= '0;
            r_dir     <= 1'b0;
            r_strobe  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pattern <= w_pattern_next;
            r_presc   <= w_presc_next;
            r_count   <= w_count_next;
            r_steps   <= w_steps_next;
            r_dir     <= w_dir_next;
            r_strobe  <= w_strobe_next;
            // Status flags are registered decodes of the state, so done
            // follows the final rotation strobe by one cycle.
            r_busy    <= (r_state == S_RUN);
            r_done    <= (r_state == S_DONE);
        end
    end

    assign seq_shiftselection_OutBUS = r_pattern;
    assign seq_strobe_Out            = r_strobe;
    assign seq_busy_Out              = r_busy;
    assign seq_done_Out              = r_done;

endmodule

// File: tb/tb_sc_shiftsel_sequencer.sv
// tb_sc_shiftsel_sequencer
// Scoreboard bench for sc_shiftsel_sequencer with TICK_DIV = 4. The stimulus
// process pushes each expected strobe/done event (bus value and the clock edge
// it follows) into a queue; the monitor pops one event per observed pulse.
module tb_sc_shiftsel_sequencer;

    localparam int W  = 8;
    localparam int TD = 4;
    localparam int SW = 4;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          load  = 1'b0;
    logic          start = 1'b0;
    logic          stop  = 1'b0;
    logic          dir   = 1'b0;
    logic [W-1:0]  pat   = '0;
    logic [SW-1:0] steps = '0;
    logic [W-1:0]  bus;
    logic          strobe, busy, done;

    int errors = 0;
    int checks = 0;
    int edges  = 0;

    typedef struct {
        bit           is_done;
        logic [W-1:0] bus;
        int           edge_n;
    } ev_t;
    ev_t exp_q[$];

    sc_shiftsel_sequencer #(
        .DATAWIDTH    (W),
        .TICK_DIV     (TD),
        .STEPS_WIDTH  (SW),
        .RESET_PATTERN(8'h0F)
    ) dut (
        .SC_RegSHIFTER_CLOCK_50    (clk),
        .SC_RegSHIFTER_RESET_InHigh(rst),
        .seq_load_In               (load),
        .seq_pattern_In            (pat),
        .seq_start_In              (start),
        .seq_stop_In               (stop),
        .seq_dir_In                (dir),
        .seq_steps_In              (steps),
        .seq_shiftselection_OutBUS (bus),
        .seq_strobe_Out            (strobe),
        .seq_busy_Out              (busy),
        .seq_done_Out              (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input bit is_done, input logic [W-1:0] b, input int e);
        ev_t ev;
        ev.is_done = is_done;
        ev.bus     = b;
        ev.edge_n  = e;
        exp_q.push_back(ev);
    endtask

    task automatic mon_event(input bit is_done);
        ev_t ev;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: edge %0d bus 0x%0h, expected no event",
                     is_done ? "done" : "strobe", edges, bus);
        end else begin
            ev = exp_q.pop_front();
            if (ev.is_done != is_done || ev.bus !== bus || ev.edge_n != edges) begin
                errors++;
                $display("FAIL event: got %s bus 0x%0h at edge %0d, expected %s bus 0x%0h at edge %0d",
                         is_done ? "done" : "strobe", bus, edges,
                         ev.is_done ? "done" : "strobe", ev.bus, ev.edge_n);
            end
        end
    endtask

    // Monitor: outputs change on posedge, so sample on negedge.
    always @(negedge clk) begin
        if (!rst) begin
            if (strobe) mon_event(1'b0);
            if (done)   mon_event(1'b1);
        end
    end

    // Returns the edge number at which inputs driven now will be sampled.
    task automatic next_slot(output int n);
        @(negedge clk);
        #1;
        n = edges + 1;
    endtask

    task automatic release_inputs();
        @(negedge clk);
        #1;
        load  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic to_negedge(input int n);
        while (edges < n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_bus",    bus,    8'h0F);
        check("reset_busy",   busy,   1'b0);
        check("reset_strobe", strobe, 1'b0);
        check("reset_done",   done,   1'b0);
        #1 rst = 1'b0;

        // Load in IDLE
        next_slot(s);
        pat = 8'h81; load = 1'b1;
        push(1'b0, 8'h81, s);
        release_inputs();

        // Counted left run: 0x81 -> 03, 06, 0C then done
        next_slot(s);
        dir = 1'b0; steps = 4'd3; start = 1'b1;
        push(1'b0, 8'h03, s + 4);
        push(1'b0, 8'h06, s + 8);
        push(1'b0, 8'h0C, s + 12);
        push(1'b1, 8'h0C, s + 13);
        release_inputs();
        to_negedge(s + 2);
        check("run1_busy_mid", busy, 1'b1);
        to_negedge(s + 12);
        check("run1_busy_last", busy, 1'b1);
        to_negedge(s + 13);
        check("run1_busy_done", busy, 1'b0);
        to_negedge(s + 15);

        // Free-running right run aborted on the third tick
        next_slot(s);
        pat = 8'h01; load = 1'b1;
        push(1'b0, 8'h01, s);
        release_inputs();
        next_slot(s);
        dir = 1'b1; steps = 4'd0; start = 1'b1;
        push(1'b0, 8'h80, s + 4);
        push(1'b0, 8'h40, s + 8);
        release_inputs();
        to_negedge(s + 11);
        #1 stop = 1'b1;
        release_inputs();
        to_negedge(s + 14);
        check("stop_busy", busy, 1'b0);
        check("stop_bus_held", bus, 8'h40);
        to_negedge(s + 22);
        check("stop_bus_still_held", bus, 8'h40);

        // Start during IDLE with load in the same cycle
        next_slot(s);
        pat = 8'hF0; load = 1'b1; start = 1'b1; dir = 1'b0; steps = 4'd1;
        push(1'b0, 8'hF0, s);
        push(1'b0, 8'hE1, s + 4);
        push(1'b1, 8'hE1, s + 5);
        release_inputs();
        to_negedge(s + 7);

        // Asynchronous reset mid-run
        next_slot(s);
        dir = 1'b0; steps = 4'd5; start = 1'b1;
        release_inputs();
        to_negedge(s + 2);
        check("pre_reset_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_bus",  bus,  8'h0F);
        check("async_reset_busy", busy, 1'b0);
        @(negedge clk);
        #1 rst = 1'b0;

        // Normal run after reset release: 0x0F -> 1E, 3C then done
        next_slot(s);
        dir = 1'b0; steps = 4'd2; start = 1'b1;
        push(1'b0, 8'h1E, s + 4);
        push(1'b0, 8'h3C, s + 8);
        push(1'b1, 8'h3C, s + 9);
        release_inputs();
        to_negedge(s + 12);

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
